// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the pipelined multiplier.
//   XLEN_DEF : default operand/result width
//   mul_op_e : operation encoding carried on the 2-bit op field
package mul_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

endpackage

// File: rtl/pipelined_mul_unit_if.sv
// pipelined_mul_unit_if: request/response bundle of the multiplier.
//   in_valid/in_ready       : request handshake (op, a, b, tag qualify it)
//   flush                   : discard every in-flight request
//   out_valid/out_ready     : result handshake (result, out_tag qualify it)
//   busy                    : any pipeline stage holds a request
// Modports: master = requester/consumer side, slave = multiplier side.
interface pipelined_mul_unit_if
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, op, a, b, tag, flush, out_ready,
        input  in_ready, out_valid, result, out_tag, busy
    );

    modport slave (
        input  in_valid, op, a, b, tag, flush, out_ready,
        output in_ready, out_valid, result, out_tag, busy
    );
endinterface

// File: rtl/mul_operand_ext.sv
// mul_operand_ext: widens both operands to XLEN+1 bits so one signed
// multiplier serves all four operations.
//   op    : operation (selects signed/unsigned treatment)
//   a, b  : raw XLEN-bit operands
//   a_ext : a sign-extended for MULH/MULHSU, zero-extended otherwise
//   b_ext : b sign-extended for MULH only, zero-extended otherwise
module mul_operand_ext
    import mul_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  mul_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN:0]   a_ext,
    output logic [XLEN:0]   b_ext
);
    logic a_signed_s;
    logic b_signed_s;

    // Decode which operands are treated as signed for this op.
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op)
            MULH:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            MULHSU:  begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            MUL:     begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
            MULHU:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
            default: begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
    end

    assign a_ext = {a_signed_s & a[XLEN-1], a};
    assign b_ext = {b_signed_s & b[XLEN-1], b};
endmodule

// File: rtl/pipelined_mul_unit.sv
// pipelined_mul_unit: LATENCY-stage multiplier with valid/ready flow control.
//   CLK_0  : clock, rising edge
//   RSTN_0 : asynchronous active-low reset (clears valid bits only)
//   bus    : request/response bundle (slave modport)
// The product is formed in front of stage 1 and the selected slice is then
// carried through the stages; synthesis may retime the multiplier across
// the stage registers. A single advance enable stalls the whole pipe.
module pipelined_mul_unit
    import mul_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic                 CLK_0,
    input  logic                 RSTN_0,
    pipelined_mul_unit_if.slave  bus
);
    mul_op_e                         op_s;
    logic [XLEN:0]                   a_ext_s;
    logic [XLEN:0]                   b_ext_s;
    logic signed [2*XLEN+1:0]        a_wide_s;
    logic signed [2*XLEN+1:0]        b_wide_s;
    logic signed [2*XLEN+1:0]        prod_s;
    logic [XLEN-1:0]                 slice_s;
    logic                            adv_s;
    logic                            unused_bits_s;

    logic [LATENCY-1:0]              valid_r;
    logic [LATENCY-1:0][XLEN-1:0]    data_r;
    logic [LATENCY-1:0][TAG_W-1:0]   tag_r;
    logic [LATENCY-1:0][1:0]         op_r;

    assign op_s = mul_op_e'(bus.op);

    mul_operand_ext #(.XLEN(XLEN)) u_ext (
        .op    (op_s),
        .a     (bus.a),
        .b     (bus.b),
        .a_ext (a_ext_s),
        .b_ext (b_ext_s)
    );

    // Full-width signed product of the extended operands.
    assign a_wide_s = {{(XLEN+1){a_ext_s[XLEN]}}, a_ext_s};
    assign b_wide_s = {{(XLEN+1){b_ext_s[XLEN]}}, b_ext_s};
    assign prod_s   = a_wide_s * b_wide_s;

    // Select the low or high half of the product according to op.
    always_comb begin
        slice_s = prod_s[2*XLEN-1:XLEN];
        case (op_s)
            MUL:     slice_s = prod_s[XLEN-1:0];
            default: slice_s = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // Only the output stage can block; bubbles are not collapsed.
    assign adv_s        = !(valid_r[LATENCY-1] && !bus.out_ready);
    assign bus.in_ready = adv_s;

    // Valid bits: flush beats stall, and a request offered with flush is dropped.
    always_ff @(posedge CLK_0 or negedge RSTN_0) begin
        if (!RSTN_0) begin
            valid_r <= '0;
        end else if (bus.flush) begin
            valid_r <= '0;
        end else if (adv_s) begin
            valid_r[0] <= bus.in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Stage payload: loaded only when advancing a valid entry, never reset.
    always_ff @(posedge CLK_0) begin
        if (adv_s && bus.in_valid) begin
            data_r[0] <= slice_s;
            tag_r[0]  <= bus.tag;
            op_r[0]   <= bus.op;
        end
        for (int i = 1; i < LATENCY; i++) begin
            if (adv_s && valid_r[i-1]) begin
                data_r[i] <= data_r[i-1];
                tag_r[i]  <= tag_r[i-1];
                op_r[i]   <= op_r[i-1];
            end
        end
    end

    assign bus.out_valid = valid_r[LATENCY-1];
    assign bus.result    = data_r[LATENCY-1];
    assign bus.out_tag   = tag_r[LATENCY-1];
    assign bus.busy      = |valid_r;

    // Top two product bits and the output-stage op are intentionally unused.
    assign unused_bits_s = ^{prod_s[2*XLEN+1:2*XLEN], op_r[LATENCY-1]};
endmodule

// File: tb/tb_pipelined_mul_unit.sv
// tb_pipelined_mul_unit: directed and random checks of pipelined_mul_unit.
// The main instance uses LATENCY=2; three more instances (LATENCY 1, 3, 4)
// share its request inputs with out_ready held high.
module tb_pipelined_mul_unit;
    import mul_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic CLK_0  = 1'b0;
    logic RSTN_0 = 1'b1;
    always #5 CLK_0 = ~CLK_0;

    pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus2 ();
    pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus1 ();
    pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus3 ();
    pipelined_mul_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus4 ();

    pipelined_mul_unit #(.XLEN(XLEN), .LATENCY(2), .TAG_W(TAG_W)) dut    (.CLK_0(CLK_0), .RSTN_0(RSTN_0), .bus(bus2));
    pipelined_mul_unit #(.XLEN(XLEN), .LATENCY(1), .TAG_W(TAG_W)) dut_l1 (.CLK_0(CLK_0), .RSTN_0(RSTN_0), .bus(bus1));
    pipelined_mul_unit #(.XLEN(XLEN), .LATENCY(3), .TAG_W(TAG_W)) dut_l3 (.CLK_0(CLK_0), .RSTN_0(RSTN_0), .bus(bus3));
    pipelined_mul_unit #(.XLEN(XLEN), .LATENCY(4), .TAG_W(TAG_W)) dut_l4 (.CLK_0(CLK_0), .RSTN_0(RSTN_0), .bus(bus4));

    // Mirror the main request inputs onto the other latency variants.
    always_comb begin
        bus1.in_valid = bus2.in_valid; bus1.op = bus2.op; bus1.a = bus2.a; bus1.b = bus2.b;
        bus1.tag = bus2.tag; bus1.flush = bus2.flush; bus1.out_ready = 1'b1;
        bus3.in_valid = bus2.in_valid; bus3.op = bus2.op; bus3.a = bus2.a; bus3.b = bus2.b;
        bus3.tag = bus2.tag; bus3.flush = bus2.flush; bus3.out_ready = 1'b1;
        bus4.in_valid = bus2.in_valid; bus4.op = bus2.op; bus4.a = bus2.a; bus4.b = bus2.b;
        bus4.tag = bus2.tag; bus4.flush = bus2.flush; bus4.out_ready = 1'b1;
    end

    typedef struct packed { logic [31:0] res; logic [4:0] tag; } exp_t;
    typedef struct packed { logic v; logic [31:0] res; logic [4:0] tag; } hist_t;

    exp_t  expq[$];
    hist_t hist[$];
    int    n_pass  = 0;
    int    n_fail  = 0;
    int    n_total = 0;

    // Reference: 64-bit integer products, high or low word by op.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        case (op)
            2'd1:    p = sa * sbv;
            2'd2:    p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // One clock on the main instance with scoreboard bookkeeping.
    task automatic tick();
        logic fl, acc, take;
        #1;
        fl   = bus2.flush;
        acc  = bus2.in_valid && bus2.in_ready && !fl;
        take = bus2.out_valid && bus2.out_ready && !fl;
        if (take) begin
            if (expq.size() == 0) begin
                chk("spurious_out", {63'd0, bus2.out_valid}, 64'd0);
            end else begin
                chk("sb_result", {32'd0, bus2.result}, {32'd0, expq[0].res});
                chk("sb_tag", {59'd0, bus2.out_tag}, {59'd0, expq[0].tag});
                void'(expq.pop_front());
            end
        end
        if (fl) expq.delete();
        if (acc) expq.push_back('{res: ref_mul(bus2.op, bus2.a, bus2.b), tag: bus2.tag});
        @(posedge CLK_0);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        bus2.in_valid = 1'b1; bus2.op = op; bus2.a = a; bus2.b = b; bus2.tag = tag;
        tick();
    endtask

    task automatic chk_lat(input int lat, input logic ov, input logic [31:0] r, input logic [4:0] t,
                           input logic rdy, input logic bz);
        int   idx;
        logic exp_busy;
        idx = hist.size() - lat;
        exp_busy = 1'b0;
        for (int j = (idx < 0) ? 0 : idx; j < hist.size(); j++) exp_busy |= hist[j].v;
        chk($sformatf("l%0d_in_ready", lat), {63'd0, rdy}, 64'd1);
        chk($sformatf("l%0d_busy", lat), {63'd0, bz}, {63'd0, exp_busy});
        if (idx >= 0) begin
            chk($sformatf("l%0d_valid", lat), {63'd0, ov}, {63'd0, hist[idx].v});
            if (hist[idx].v) begin
                chk($sformatf("l%0d_result", lat), {32'd0, r}, {32'd0, hist[idx].res});
                chk($sformatf("l%0d_tag", lat), {59'd0, t}, {59'd0, hist[idx].tag});
            end
        end
    endtask

    initial begin
        bus2.in_valid = 1'b0; bus2.op = 2'd0; bus2.a = 32'd0; bus2.b = 32'd0;
        bus2.tag = 5'd0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;

        // Reset state
        #2 RSTN_0 = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, bus2.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, bus2.busy}, 64'd0);
        chk("rst_in_ready", {63'd0, bus2.in_ready}, 64'd1);
        @(posedge CLK_0); #1;
        RSTN_0 = 1'b1;
        tick();
        chk("post_rst_out_valid", {63'd0, bus2.out_valid}, 64'd0);

        // MUL of all-ones: result 1 exactly two cycles after acceptance
        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
        bus2.in_valid = 1'b0;
        chk("mul_early_valid", {63'd0, bus2.out_valid}, 64'd0);
        tick();
        chk("mul_valid", {63'd0, bus2.out_valid}, 64'd1);
        chk("mul_result", {32'd0, bus2.result}, 64'h1);
        chk("mul_tag", {59'd0, bus2.out_tag}, 64'd7);
        tick();

        // High-half ops on all-ones, back to back
        issue(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        chk("mulhu_ones", {32'd0, bus2.result}, 64'hFFFF_FFFE);
        issue(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        chk("mulh_ones", {32'd0, bus2.result}, 64'h0);
        bus2.in_valid = 1'b0;
        tick();
        chk("mulhsu_ones", {32'd0, bus2.result}, 64'hFFFF_FFFF);
        tick();

        // MULH of min-int squared, tags 1..4 on consecutive cycles
        for (int k = 1; k <= 4; k++) begin
            issue(2'd1, 32'h8000_0000, 32'h8000_0000, 5'(k));
            if (k >= 2) begin
                chk("seq_valid", {63'd0, bus2.out_valid}, 64'd1);
                chk("seq_tag", {59'd0, bus2.out_tag}, 64'(k - 1));
                chk("mulh_min", {32'd0, bus2.result}, 64'h4000_0000);
            end
        end
        bus2.in_valid = 1'b0;
        tick();
        chk("seq_tag_last", {59'd0, bus2.out_tag}, 64'd4);
        tick();

        // Stall with full pipe for three cycles
        bus2.out_ready = 1'b0;
        issue(2'd0, pick(), pick(), 5'd10);
        issue(2'd1, pick(), pick(), 5'd11);
        bus2.tag = 5'd12; bus2.a = pick(); bus2.b = pick();
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_in_ready", {63'd0, bus2.in_ready}, 64'd0);
            chk("stall_valid", {63'd0, bus2.out_valid}, 64'd1);
            chk("stall_tag", {59'd0, bus2.out_tag}, 64'd10);
            chk("stall_result", {32'd0, bus2.result}, {32'd0, expq[0].res});
            tick();
        end
        bus2.out_ready = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        repeat (4) tick();
        chk("stall_drain", 64'(expq.size()), 64'd0);

        // Flush with two in flight and one offered
        bus2.out_ready = 1'b0;
        issue(2'd3, pick(), pick(), 5'd20);
        issue(2'd2, pick(), pick(), 5'd21);
        bus2.tag = 5'd22; bus2.flush = 1'b1;
        tick();
        chk("flush_out_valid", {63'd0, bus2.out_valid}, 64'd0);
        chk("flush_busy", {63'd0, bus2.busy}, 64'd0);
        bus2.flush = 1'b0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        repeat (4) tick();
        chk("flush_after", {63'd0, bus2.out_valid}, 64'd0);
        bus2.flush = 1'b1;
        issue(2'd0, pick(), pick(), 5'd23);
        bus2.flush = 1'b0; bus2.in_valid = 1'b0;
        chk("flush_offer_busy", {63'd0, bus2.busy}, 64'd0);
        repeat (3) tick();
        chk("flush_offer_out", {63'd0, bus2.out_valid}, 64'd0);

        // Asynchronous reset mid-stream
        issue(2'd0, pick(), pick(), 5'd30);
        issue(2'd1, pick(), pick(), 5'd31);
        #2 RSTN_0 = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, bus2.out_valid}, 64'd0);
        chk("arst_in_ready", {63'd0, bus2.in_ready}, 64'd1);
        chk("arst_busy", {63'd0, bus2.busy}, 64'd0);
        expq.delete();
        bus2.in_valid = 1'b0;
        @(posedge CLK_0); #1;
        RSTN_0 = 1'b1;
        repeat (4) tick();
        chk("arst_no_stale", {63'd0, bus2.out_valid}, 64'd0);

        // Random traffic with stalls and flushes on the main instance
        for (int i = 0; i < 400; i++) begin
            bus2.in_valid  = ($urandom_range(0, 3) != 0);
            bus2.op        = 2'($urandom_range(0, 3));
            bus2.a         = pick();
            bus2.b         = pick();
            bus2.tag       = 5'($urandom);
            bus2.out_ready = ($urandom_range(0, 3) != 0);
            bus2.flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        bus2.in_valid = 1'b0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_drain", 64'(expq.size()), 64'd0);

        // Random traffic on all latencies, no backpressure
        hist.delete();
        for (int i = 0; i < 200; i++) begin
            bus2.in_valid = ($urandom_range(0, 3) != 0);
            bus2.op       = 2'($urandom_range(0, 3));
            bus2.a        = pick();
            bus2.b        = pick();
            bus2.tag      = 5'($urandom);
            hist.push_back('{v: bus2.in_valid, res: ref_mul(bus2.op, bus2.a, bus2.b), tag: bus2.tag});
            tick();
            chk_lat(1, bus1.out_valid, bus1.result, bus1.out_tag, bus1.in_ready, bus1.busy);
            chk_lat(2, bus2.out_valid, bus2.result, bus2.out_tag, bus2.in_ready, bus2.busy);
            chk_lat(3, bus3.out_valid, bus3.result, bus3.out_tag, bus3.in_ready, bus3.busy);
            chk_lat(4, bus4.out_valid, bus4.result, bus4.out_tag, bus4.in_ready, bus4.busy);
        end
        bus2.in_valid = 1'b0;
        repeat (6) tick();
        chk("final_drain", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
